// File: rtl/world_pixel_fetch.sv
// World-map pixel fetch: beam position + double-buffered camera scroll -> index ROM
// address, then ROM data re-registered as a palette index aligned with active video.
module world_pixel_fetch #(
  parameter int WORLD_W = 3584,
  parameter int WORLD_H = 240,
  parameter int VIEW_W  = 320,
  parameter int ADDR_W  = 20,
  parameter int ROM_LAT = 1
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic [9:0]        draw_x_i,
  input  logic [9:0]        draw_y_i,
  input  logic              active_in_i,
  input  logic              frame_start_i,
  input  logic [11:0]       scroll_in_i,
  input  logic              scroll_we_i,
  output logic              scroll_pending_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [3:0]        rom_q_i,
  output logic [3:0]        index_o,
  output logic              active_out_o
);

  localparam logic [11:0] SCROLL_MAX = 12'(WORLD_W - VIEW_W);
  localparam logic [12:0] WW13       = 13'(WORLD_W);
  localparam logic [8:0]  WY_MAX     = 9'(WORLD_H - 1);

  logic [11:0]       scroll_sat;
  logic [11:0]       scroll_shadow_q, scroll_shadow_d;
  logic [11:0]       scroll_live_q, scroll_live_d;
  logic              scroll_pending_q, scroll_pending_d;
  logic [12:0]       wx_sum, wx;
  logic [8:0]        wy;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [ROM_LAT:0]  vld_pipe_q;
  logic [3:0]        index_q;
  logic              active_out_q;
  logic              unused_lsbs;

  // Pixel doubling drops the beam LSBs.
  assign unused_lsbs = ^{draw_x_i[0], draw_y_i[0]};

  // Live scroll only moves on frame_start so a frame never tears; a write landing on
  // the frame_start cycle bypasses the shadow.
  always_comb begin
    scroll_sat       = (scroll_in_i > SCROLL_MAX) ? SCROLL_MAX : scroll_in_i;
    scroll_shadow_d  = scroll_shadow_q;
    scroll_live_d    = scroll_live_q;
    scroll_pending_d = scroll_pending_q;
    if (scroll_we_i) begin
      scroll_shadow_d  = scroll_sat;
      scroll_pending_d = 1'b1;
    end
    if (frame_start_i) begin
      if (scroll_we_i) begin
        scroll_live_d    = scroll_sat;
        scroll_pending_d = 1'b0;
      end else if (scroll_pending_q) begin
        scroll_live_d    = scroll_shadow_q;
        scroll_pending_d = 1'b0;
      end
    end
  end

  always_comb begin
    wx_sum     = 13'(draw_x_i[9:1]) + {1'b0, scroll_live_q};
    wx         = (wx_sum >= WW13) ? wx_sum - WW13 : wx_sum;
    wy         = (draw_y_i[9:1] > WY_MAX) ? WY_MAX : draw_y_i[9:1];
    // Address held during blanking to keep the ROM bus quiet.
    rom_addr_d = active_in_i ? (ADDR_W'(wy) * ADDR_W'(WORLD_W) + ADDR_W'(wx)) : rom_addr_q;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      scroll_shadow_q  <= '0;
      scroll_live_q    <= '0;
      scroll_pending_q <= 1'b0;
      rom_addr_q       <= '0;
      vld_pipe_q       <= '0;
      index_q          <= 4'h0;
      active_out_q     <= 1'b0;
    end else begin
      scroll_shadow_q  <= scroll_shadow_d;
      scroll_live_q    <= scroll_live_d;
      scroll_pending_q <= scroll_pending_d;
      rom_addr_q       <= rom_addr_d;
      vld_pipe_q       <= {vld_pipe_q[ROM_LAT-1:0], active_in_i};
      index_q          <= vld_pipe_q[ROM_LAT] ? rom_q_i : 4'h0;
      active_out_q     <= vld_pipe_q[ROM_LAT];
    end
  end

  assign scroll_pending_o = scroll_pending_q;
  assign rom_addr_o       = rom_addr_q;
  assign index_o          = index_q;
  assign active_out_o     = active_out_q;

endmodule

// File: doc/world_pixel_fetch.md
Name: world_pixel_fetch

Overview:
- Pixel-fetch stage directly upstream of the world palette lookup.
- Takes the VGA beam position plus a camera scroll offset and computes the world-map tile-image ROM address. It drives an external synchronous index ROM and returns the 4-bit palette index, aligned with an active-video flag.
- The camera scroll is double-buffered so that a scroll change never tears mid-frame.
- Output index feeds the palette directly; active_out gates the RGB drive.

Parameters:
- WORLD_W, 3584, world image width in world pixels.
- WORLD_H, 240, world image height in world pixels.
- VIEW_W, 320, visible world columns; screen is 640x480 at 2x scale.
- ADDR_W, 20, ROM address width; must satisfy 2^ADDR_W >= WORLD_W*WORLD_H.
- ROM_LAT, 1, external ROM read latency in cycles (1 or 2).

Ports:
- clk  in  1  pixel clock.
- reset_n  in  1  asynchronous, active-low reset.
- draw_x  in  10  beam column, 0..799.
- draw_y  in  10  beam row, 0..524.
- active_in  in  1  beam inside the 640x480 visible area.
- frame_start  in  1  one-cycle pulse at the start of each frame (vsync edge).
- scroll_in  in  12  requested camera x, in world pixels.
- scroll_we  in  1  write strobe for scroll_in.
- scroll_pending  out  1  a written scroll value is waiting for frame_start.
- rom_addr  out  ADDR_W  registered ROM read address.
- rom_q  in  4  ROM data, valid ROM_LAT cycles after rom_addr.
- index  out  4  palette index to the palette stage.
- active_out  out  1  active_in delayed to align with index.

Behaviour:
- Reset, asynchronous on reset_n low: scroll_shadow=0, scroll_live=0, scroll_pending=0, rom_addr=0, index=0, active_out=0, and all pipeline flags cleared.
- Scroll write, when scroll_we=1:
  - scroll_shadow <= min(scroll_in, WORLD_W-VIEW_W), i.e. saturate at 3264 by default.
  - scroll_pending <= 1.
  - There is no back-pressure; the last write before frame_start wins.
- Frame start, when frame_start=1 and scroll_pending=1: scroll_live <= scroll_shadow and scroll_pending <= 0.
- Simultaneous scroll_we and frame_start in the same cycle: the new (saturated) scroll_in is forwarded straight to scroll_live, and scroll_pending ends at 0.
- scroll_live changes only on a frame_start cycle.
- Stage A, address generation, registered on every cycle:
  - wx = (draw_x>>1) + scroll_live, computed 13 bits wide.
  - If wx >= WORLD_W, subtract WORLD_W (wrap-around; unreachable when saturated, but required).
  - wy = draw_y>>1; if wy >= WORLD_H, force wy = WORLD_H-1.
  - rom_addr <= wy*WORLD_W + wx, truncated to ADDR_W bits.
  - When active_in=0: rom_addr holds its previous value, to save ROM toggling.
- active_in is carried through a shift register of length 1+ROM_LAT+1.
- Stage C, output register:
  - index <= rom_q if the delayed active flag is 1, else 4'h0 (sky index).
  - active_out <= the delayed active flag.
- Total latency from draw_x/draw_y/active_in to index/active_out is ROM_LAT+2 cycles (3 by default), fixed. The pipeline never stalls.
- Reset asserted mid-line: outputs go to reset values immediately. After release, the first ROM_LAT+2 cycles give active_out=0 regardless of active_in.
- Out-of-range draw_x (>=640) while active_in=1 is an upstream error; the address is still computed with no clamp on x, but wx is wrapped.

Test Plan:
- Reset, then hold active_in=1 with draw_x=0, draw_y=0, scroll_live=0 -> rom_addr=0 one cycle later; index=rom_q and active_out=1 three cycles later; all outputs 0 during reset.
- scroll_we with scroll_in=100 mid-frame, beam at draw_x=10, draw_y=20 -> scroll_pending=1 and rom_addr stays 10*3584+5=35845. After frame_start: scroll_pending=0, and the same beam position gives rom_addr=35945.
- scroll_in=4000 -> saturated to 3264. draw_x=638, draw_y=479 -> wx=3583, wy=239, rom_addr=239*3584+3583=860159.
- scroll_we and frame_start in the same cycle with scroll_in=50 -> scroll_live=50 next cycle and scroll_pending=0.
- active_in toggling 1,0,1 with ROM returning 4'hA -> index=A,0,A and active_out=1,0,1, each 3 cycles delayed; rom_addr held while active_in=0.
- reset_n pulsed low mid-line -> index and active_out drop to 0 asynchronously; scroll_live=0; active_out stays 0 for 3 cycles after release.
